// File: rtl/boot_seq_pkg.sv
// Shared definitions for the boot sequencer: default sizing and the session state encoding.
package boot_seq_pkg;

  localparam int ADDR_W_DEF  = 11;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 4096;
  localparam int RD_LAT_DEF  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DUMP_ADDR,
    ST_DUMP_WAIT,
    ST_DUMP_OUT,
    ST_FIN
  } bootState_t;

endpackage

// File: rtl/boot_run_timer.sv
// Free-running cycle counter held at zero while disabled; flags when it reaches a terminal value.
module boot_run_timer #(
  parameter int CNT_W = 13
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_last,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_count <= '0;
    else if (!i_en) r_count <= '0;
    else            r_count <= r_count + CNT_W'(1);
  end

  assign o_tc = i_en && (r_count == i_last);

endmodule

// File: rtl/prog_boot_sequencer.sv
// Runs one core session: stream program into instruction memory, release the core,
// wait for done (or time out), then stream a window of data memory back out.
module prog_boot_sequencer
  import boot_seq_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int RD_LAT  = RD_LAT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_prog_len,
  input  logic [ADDR_W-1:0] i_dump_base,
  input  logic [ADDR_W-1:0] i_dump_len,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [DATA_W-1:0] i_s_data,
  output logic              o_cpu_rst,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_addr,
  output logic              o_ins_we,
  output logic [ADDR_W-1:0] o_data_addr,
  input  logic              i_cpu_done,
  input  logic [DATA_W-1:0] i_memory_out,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_busy,
  output logic              o_finished,
  output logic              o_timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + RD_LAT) + 1;
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LAT - 1);

  bootState_t        r_state, w_nextState;
  logic [ADDR_W-1:0] r_progLen, r_dumpBase, r_dumpLen, r_wrIdx, r_rdIdx;
  logic [ADDR_W-1:0] r_instrAddr, r_dataAddr;
  logic [DATA_W-1:0] r_instr, r_mData;
  logic              r_insWe, r_timeoutErr;
  logic              w_accept, w_loadHs, w_lastLoad, w_dumpHs, w_lastDump, w_runTimeout;
  logic              w_timerEn, w_timerTc;
  logic [CNT_W-1:0]  w_timerLast;

  // One counter serves both the RUN watchdog and the memory read-latency wait.
  assign w_timerEn   = (r_state == ST_RUN) || (r_state == ST_DUMP_WAIT);
  assign w_timerLast = (r_state == ST_RUN) ? RUN_LAST : WAIT_LAST;

  boot_run_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_timerEn),
    .i_last  (w_timerLast),
    .o_tc    (w_timerTc)
  );

  assign w_accept     = (r_state == ST_IDLE) && i_start && !i_abort;
  assign w_loadHs     = (r_state == ST_LOAD) && i_s_valid && !i_abort;
  assign w_lastLoad   = w_loadHs && (r_wrIdx == r_progLen - ADDR_W'(1));
  assign w_dumpHs     = (r_state == ST_DUMP_OUT) && i_m_ready && !i_abort;
  assign w_lastDump   = w_dumpHs && ((r_rdIdx + ADDR_W'(1)) == r_dumpLen);
  assign w_runTimeout = (r_state == ST_RUN) && !i_cpu_done && w_timerTc && !i_abort;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:      if (i_start) w_nextState = (i_prog_len == '0) ? ST_RUN : ST_LOAD;
      ST_LOAD:      if (w_lastLoad) w_nextState = ST_RUN;
      ST_RUN: begin
        if (i_cpu_done)     w_nextState = (r_dumpLen == '0) ? ST_FIN : ST_DUMP_ADDR;
        else if (w_timerTc) w_nextState = ST_IDLE;
      end
      ST_DUMP_ADDR: w_nextState = ST_DUMP_WAIT;
      ST_DUMP_WAIT: if (w_timerTc) w_nextState = ST_DUMP_OUT;
      ST_DUMP_OUT:  if (w_dumpHs) w_nextState = w_lastDump ? ST_FIN : ST_DUMP_ADDR;
      ST_FIN:       w_nextState = ST_IDLE;
      default:      w_nextState = ST_IDLE;
    endcase
    if (i_abort) w_nextState = ST_IDLE;
  end

  // Session datapath: parameter capture, instruction writes, dump address walk and capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_progLen    <= '0;
      r_dumpBase   <= '0;
      r_dumpLen    <= '0;
      r_wrIdx      <= '0;
      r_rdIdx      <= '0;
      r_instr      <= '0;
      r_instrAddr  <= '0;
      r_insWe      <= 1'b0;
      r_dataAddr   <= '0;
      r_mData      <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_insWe <= 1'b0;
      if (w_accept) begin
        r_progLen    <= i_prog_len;
        r_dumpBase   <= i_dump_base;
        r_dumpLen    <= i_dump_len;
        r_wrIdx      <= '0;
        r_timeoutErr <= 1'b0;
      end
      if (w_loadHs) begin
        r_instr     <= i_s_data;
        r_instrAddr <= r_wrIdx;
        r_insWe     <= 1'b1;
        r_wrIdx     <= r_wrIdx + ADDR_W'(1);
      end
      if (w_runTimeout) r_timeoutErr <= 1'b1;
      if ((r_state == ST_RUN) && i_cpu_done && !i_abort) begin
        r_dataAddr <= r_dumpBase;
        r_rdIdx    <= '0;
      end
      if ((r_state == ST_DUMP_WAIT) && w_timerTc && !i_abort) r_mData <= i_memory_out;
      if (w_dumpHs) begin
        r_rdIdx    <= r_rdIdx + ADDR_W'(1);
        r_dataAddr <= r_dataAddr + ADDR_W'(1);
      end
    end
  end

  // The core is only out of reset while running and while its data memory is read back.
  assign o_cpu_rst     = !((r_state == ST_RUN) || (r_state == ST_DUMP_ADDR) ||
                           (r_state == ST_DUMP_WAIT) || (r_state == ST_DUMP_OUT));
  assign o_s_ready     = (r_state == ST_LOAD) && !i_abort;
  assign o_m_valid     = (r_state == ST_DUMP_OUT);
  assign o_finished    = (r_state == ST_FIN);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_instr       = r_instr;
  assign o_instr_addr  = r_instrAddr;
  assign o_ins_we      = r_insWe;
  assign o_data_addr   = r_dataAddr;
  assign o_m_data      = r_mData;
  assign o_timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_prog_boot_sequencer.sv
// Scoreboard bench for prog_boot_sequencer: sessions queue expected writes/dump words, a monitor checks them.
module tb_prog_boot_sequencer;

  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 32;
  localparam int TIMEOUT   = 16;
  localparam int RD_LAT    = 1;
  localparam int MEM_WORDS = 2048;

  logic              clk = 1'b0;
  logic              rstN = 1'b0;
  logic              start, abort, sValid, sReady, cpuRst, insWe, cpuDone;
  logic              mValid, mReady, busy, finished, timeoutErr;
  logic [ADDR_W-1:0] progLenIn, dumpBaseIn, dumpLenIn, instrAddr, dataAddr;
  logic [DATA_W-1:0] sData, instr, memOut, mData;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } insExp_t;

  insExp_t           expInsQ[$];
  logic [DATA_W-1:0] expDumpQ[$];
  logic [DATA_W-1:0] progBuf[$];
  logic [DATA_W-1:0] dmem[MEM_WORDS];
  insExp_t           monIns;
  int                pendingFin = 0;
  int                nVectors = 0;
  int                nMiss = 0;
  bit                hung = 1'b0;

  always #5 clk = ~clk;

  prog_boot_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .RD_LAT(RD_LAT)
  ) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_abort(abort),
    .i_prog_len(progLenIn), .i_dump_base(dumpBaseIn), .i_dump_len(dumpLenIn),
    .i_s_valid(sValid), .o_s_ready(sReady), .i_s_data(sData),
    .o_cpu_rst(cpuRst), .o_instr(instr), .o_instr_addr(instrAddr), .o_ins_we(insWe),
    .o_data_addr(dataAddr), .i_cpu_done(cpuDone), .i_memory_out(memOut),
    .o_m_valid(mValid), .i_m_ready(mReady), .o_m_data(mData),
    .o_busy(busy), .o_finished(finished), .o_timeout_err(timeoutErr)
  );

  // Data memory with one cycle of read latency
  initial memOut = '0;
  always @(posedge clk) memOut <= dmem[dataAddr];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT presents a write, a dump word or a finish pulse
  always @(negedge clk) begin
    if (insWe) begin
      if (expInsQ.size() == 0) checkOutput("ins_we unexpected", 64'(insWe), 64'd0);
      else begin
        monIns = expInsQ.pop_front();
        checkOutput("instr_addr", 64'(instrAddr), 64'(monIns.addr));
        checkOutput("instr", 64'(instr), 64'(monIns.data));
      end
    end
    if (mValid) begin
      if (expDumpQ.size() == 0) checkOutput("m_valid unexpected", 64'(mValid), 64'd0);
      else begin
        checkOutput("m_data", 64'(mData), 64'(expDumpQ[0]));
        if (mReady) void'(expDumpQ.pop_front());
      end
    end
    if (finished) begin
      checkOutput("finished expected", 64'(finished), 64'(pendingFin > 0));
      checkOutput("cpu_rst during finish", 64'(cpuRst), 64'd1);
      checkOutput("dump words left at finish", 64'(expDumpQ.size()), 64'd0);
      if (pendingFin > 0) pendingFin--;
    end
  end

  // One session. readyMode: 0 always ready, 1 random, 2 five-cycle stall on word 2.
  // gapMode: 0 back-to-back, 1 random gaps, 2 two idle cycles before word 1.
  task automatic applyStimulus(input int progLen, input int dumpBase, input int dumpLen,
                               input int doneAfter, input int gapMode, input int readyMode,
                               input bit expectTimeout, input bit abortDump, input bit resetLoad);
    int  nGap, seen, stall, guard;
    bit  hs;
    if (hung) return;
    while (progBuf.size() < progLen) progBuf.push_back($urandom);
    for (int j = 0; j < dumpLen; j++) expDumpQ.push_back(dmem[(dumpBase + j) % MEM_WORDS]);
    if (!expectTimeout && !abortDump && !resetLoad) pendingFin++;
    progLenIn  = ADDR_W'(progLen);
    dumpBaseIn = ADDR_W'(dumpBase);
    dumpLenIn  = ADDR_W'(dumpLen);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("timeout_err cleared by start", 64'(timeoutErr), 64'd0);
    checkOutput("busy after start", 64'(busy), 64'd1);
    for (int k = 0; k < progLen; k++) begin
      nGap = (gapMode == 1) ? int'($urandom_range(0, 2)) : ((gapMode == 2 && k == 1) ? 2 : 0);
      repeat (nGap) begin
        sValid = 1'b0;
        @(posedge clk); #1;
      end
      sValid = 1'b1;
      sData  = progBuf[k];
      expInsQ.push_back(insExp_t'{addr: ADDR_W'(k), data: progBuf[k]});
      if (resetLoad && k == 1) begin
        #2 rstN = 1'b0;
        #1;
        checkOutput("reset cpu_rst", 64'(cpuRst), 64'd1);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset s_ready", 64'(sReady), 64'd0);
        checkOutput("reset ins_we", 64'(insWe), 64'd0);
        checkOutput("reset instr", 64'(instr), 64'd0);
        checkOutput("reset instr_addr", 64'(instrAddr), 64'd0);
        checkOutput("reset flags", 64'({mValid, finished, timeoutErr}), 64'd0);
        checkOutput("reset data_addr/m_data", 64'({dataAddr, mData}), 64'd0);
        sValid = 1'b0;
        expInsQ.delete();
        expDumpQ.delete();
        progBuf.delete();
        #2 rstN = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      checkOutput("s_ready in LOAD", 64'(sReady), 64'd1);
      @(posedge clk); #1;
    end
    sValid = 1'b0;
    progBuf.delete();
    if (progLen > 0) checkOutput("s_ready after last word", 64'(sReady), 64'd0);
    checkOutput("cpu_rst released in RUN", 64'(cpuRst), 64'd0);
    if (expectTimeout) begin
      repeat (TIMEOUT - 1) @(posedge clk);
      #1;
      checkOutput("still running before timeout", 64'({busy, cpuRst, timeoutErr}), 64'b100);
      @(posedge clk); #1;
      checkOutput("timeout_err set", 64'(timeoutErr), 64'd1);
      checkOutput("idle after timeout", 64'({busy, cpuRst}), 64'b01);
      expDumpQ.delete();
      repeat (3) @(posedge clk);
      #1;
      return;
    end
    repeat (doneAfter) @(posedge clk);
    #1;
    cpuDone = 1'b1;
    @(posedge clk); #1;
    cpuDone = 1'b0;
    seen = 0; stall = 5; guard = 0;
    while (busy && guard < 500) begin
      if (abortDump && mValid) begin
        mReady = 1'b0;
        abort  = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("m_valid after abort", 64'(mValid), 64'd0);
        checkOutput("idle after abort", 64'({busy, cpuRst}), 64'b01);
        expDumpQ.delete();
        break;
      end
      if (readyMode == 0) mReady = 1'b1;
      else if (readyMode == 1) mReady = 1'($urandom_range(0, 1));
      else if (mValid && seen == 2 && stall > 0) begin
        mReady = 1'b0;
        stall--;
      end else mReady = 1'b1;
      hs = mValid && mReady;
      @(posedge clk); #1;
      if (hs) seen++;
      guard++;
    end
    mReady = 1'b0;
    checkOutput("session completes in budget", 64'(busy), 64'd0);
    if (busy) begin
      hung = 1'b1;
      return;
    end
    checkOutput("cpu_rst back in IDLE", 64'(cpuRst), 64'd1);
    checkOutput("dump words all delivered", 64'(expDumpQ.size()), 64'd0);
    checkOutput("finish pulse seen", 64'(pendingFin), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    start = 0; abort = 0; sValid = 0; sData = '0; cpuDone = 0; mReady = 0;
    progLenIn = '0; dumpBaseIn = '0; dumpLenIn = '0;
    for (int i = 0; i < MEM_WORDS; i++) dmem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset cpu_rst", 64'(cpuRst), 64'd1);
    checkOutput("reset outputs", 64'({sReady, insWe, mValid, finished, timeoutErr, busy}), 64'd0);
    checkOutput("reset data regs", 64'({instrAddr, dataAddr}), 64'd0);
    checkOutput("reset instr/m_data", 64'({instr, mData}), 64'd0);
    rstN = 1'b1;
    @(posedge clk); #1;

    progBuf = '{32'h24020005, 32'hac220000, 32'h24020002};
    applyStimulus(3, 100, 2, 3, 0, 0, 0, 0, 0);
    applyStimulus(2, 200, 1, 2, 2, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) dmem[4 + i] = 32'(i + 1);
    applyStimulus(2, 4, 6, 10, 0, 0, 0, 0, 0);
    applyStimulus(1, 4, 6, 1, 0, 2, 0, 0, 0);
    applyStimulus(2, 0, 3, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 2045, 6, 15, 0, 1, 0, 0, 0);
    applyStimulus(0, 7, 0, 4, 0, 0, 0, 0, 0);
    applyStimulus(2, 30, 4, 2, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 2, 0, 0, 0, 1, 0, 0);
    applyStimulus(4, 0, 2, 2, 0, 0, 0, 0, 1);
    for (int r = 0; r < 25; r++)
      applyStimulus(int'($urandom_range(0, 6)), int'($urandom_range(0, MEM_WORDS - 1)),
                    int'($urandom_range(0, 5)), int'($urandom_range(0, TIMEOUT - 1)),
                    1, int'($urandom_range(0, 1)), 0, 0, 0);
    checkOutput("no pending writes", 64'(expInsQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, vectors=%0d", nVectors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
